// File: rtl/mips_wb_queue.sv
// rtl/mips_wb_queue.sv - write-back buffer ahead of the MIPS register file write port
//
// Purpose:
//   Holds register write requests in a DEPTH-entry FIFO and drains one entry
//   per cycle into the register file. Two combinational lookup ports return
//   the newest pending value for a register, so readers see data that has
//   not yet been written.
//
// Optional feature (macro WBQ_COALESCE_EN):
//   When defined, a push whose regnum equals the newest stored entry's regnum
//   overwrites that entry's data instead of allocating a new one.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   in_valid/in_ready            write request handshake
//   in_regnum, in_data           request destination register and value
//   drain_enable                 regfile write port available
//   wr_regnum, wr_data           head entry, to regfile (0 when empty)
//   writeenable                  regfile write strobe
//   lk1_regnum/lk1_hit/lk1_data  forwarding lookup port 1
//   lk2_regnum/lk2_hit/lk2_data  forwarding lookup port 2
//   count, full, empty           occupancy status

module mips_wb_queue #(
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_regnum,
  input  logic [31:0]     in_data,
  input  logic            drain_enable,
  output logic [4:0]      wr_regnum,
  output logic [31:0]     wr_data,
  output logic            writeenable,
  input  logic [4:0]      lk1_regnum,
  output logic            lk1_hit,
  output logic [31:0]     lk1_data,
  input  logic [4:0]      lk2_regnum,
  output logic            lk2_hit,
  output logic [31:0]     lk2_data,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic            empty
);

  localparam int PW = $clog2(DEPTH);

  logic [4:0]      reg_mem  [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   newest;
  logic [CNTW-1:0] cnt;

  logic pop;
  logic coalesce;
  logic accept;
  logic alloc;
  logic update;

  assign count  = cnt;
  assign full   = (cnt == CNTW'(DEPTH));
  assign empty  = (cnt == '0);
  assign newest = tail - PW'(1);

  assign pop         = !empty && drain_enable;
  assign writeenable = pop;
  assign wr_regnum   = empty ? 5'd0  : reg_mem[head];
  assign wr_data     = empty ? 32'd0 : data_mem[head];

`ifdef WBQ_COALESCE_EN
  logic tail_match;
  logic popping_newest;

  // Stored entries never hold $0, so a $0 request can never coalesce.
  assign tail_match     = !empty && (in_regnum != 5'd0) && (reg_mem[newest] == in_regnum);
  // The newest entry is also the head only when exactly one entry is stored;
  // if it leaves this cycle the request must take a fresh slot instead.
  assign popping_newest = pop && (cnt == CNTW'(1));
  assign coalesce       = tail_match && !popping_newest;
  assign in_ready       = !full || coalesce;
`else
  assign coalesce = 1'b0;
  assign in_ready = !full;
`endif

  assign accept = in_valid && in_ready;
  assign alloc  = accept && (in_regnum != 5'd0) && !coalesce;
  assign update = accept && coalesce;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (alloc) tail <= tail + PW'(1);
      if (pop)   head <= head + PW'(1);
      case ({alloc, pop})
        2'b10:   cnt <= cnt + CNTW'(1);
        2'b01:   cnt <= cnt - CNTW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; every read is qualified by the occupancy count.
  always_ff @(posedge clock) begin
    if (alloc) begin
      reg_mem[tail]  <= in_regnum;
      data_mem[tail] <= in_data;
    end else if (update) begin
      data_mem[newest] <= in_data;
    end
  end

  // Walk from oldest to newest so that a later match overrides an earlier one.
  always_comb begin
    lk1_hit  = 1'b0;
    lk1_data = 32'd0;
    lk2_hit  = 1'b0;
    lk2_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNTW'(i) < cnt) begin
        if ((lk1_regnum != 5'd0) && (reg_mem[head + PW'(i)] == lk1_regnum)) begin
          lk1_hit  = 1'b1;
          lk1_data = data_mem[head + PW'(i)];
        end
        if ((lk2_regnum != 5'd0) && (reg_mem[head + PW'(i)] == lk2_regnum)) begin
          lk2_hit  = 1'b1;
          lk2_data = data_mem[head + PW'(i)];
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_wb_queue.sv
// tb/tb_mips_wb_queue.sv - self-checking bench for mips_wb_queue

module tb_mips_wb_queue;

`ifdef WBQ_COALESCE_EN
  localparam bit C = 1'b1;
`else
  localparam bit C = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_regnum = '0;
  logic [31:0] in_data = '0;
  logic        drain_enable = 1'b0;
  logic [4:0]  wr_regnum;
  logic [31:0] wr_data;
  logic        writeenable;
  logic [4:0]  lk1_regnum = '0;
  logic        lk1_hit;
  logic [31:0] lk1_data;
  logic [4:0]  lk2_regnum = '0;
  logic        lk2_hit;
  logic [31:0] lk2_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int total = 0;
  int bad   = 0;

  mips_wb_queue #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_regnum(in_regnum), .in_data(in_data),
    .drain_enable(drain_enable),
    .wr_regnum(wr_regnum), .wr_data(wr_data), .writeenable(writeenable),
    .lk1_regnum(lk1_regnum), .lk1_hit(lk1_hit), .lk1_data(lk1_data),
    .lk2_regnum(lk2_regnum), .lk2_hit(lk2_hit), .lk2_data(lk2_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [4:0]  rn;
    logic [31:0] d;
    logic        de;
    logic [4:0]  l1;
    logic [4:0]  l2;
    int          cnt;
    logic        we;
    logic [4:0]  wrn;
    logic [31:0] wd;
    logic        rdy;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [4:0] rn, logic [31:0] d, logic de,
                              logic [4:0] l1, logic [4:0] l2, int cnt, logic we,
                              logic [4:0] wrn, logic [31:0] wd, logic rdy,
                              logic h1, logic [31:0] d1, logic h2, logic [31:0] d2);
    vec_t r;
    r.v = v; r.rn = rn; r.d = d; r.de = de; r.l1 = l1; r.l2 = l2;
    r.cnt = cnt; r.we = we; r.wrn = wrn; r.wd = wd; r.rdy = rdy;
    r.h1 = h1; r.d1 = d1; r.h2 = h2; r.d2 = d2;
    return r;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [4:0] rn, logic [31:0] d, logic de,
                       logic [4:0] l1, logic [4:0] l2);
    in_valid = v; in_regnum = rn; in_data = d; drain_enable = de;
    lk1_regnum = l1; lk2_regnum = l2;
  endtask

  initial begin
    // Rows: inputs for one cycle, then outputs expected just before its rising edge.
    //            v  rn  data            de l1 l2  cnt we wrn wd              rdy h1 d1              h2 d2
    tbl.push_back(mk(0, 0, 32'h0,        1, 5, 7,  0, 0, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 5, 32'h11111111, 1, 5, 0,  0, 0, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 5, 0,  1, 1, 5, 32'h11111111, 1,  1, 32'h11111111, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 5, 0,  0, 0, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0));
    // fill with drain stalled, 5th request refused
    tbl.push_back(mk(1, 1, 32'hA1,       0, 0, 0,  0, 0, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 2, 32'hA2,       0, 1, 0,  1, 0, 1, 32'hA1,       1,  1, 32'hA1,       0, 32'h0));
    tbl.push_back(mk(1, 3, 32'hA3,       0, 0, 0,  2, 0, 1, 32'hA1,       1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 4, 32'hA4,       0, 3, 0,  3, 0, 1, 32'hA1,       1,  1, 32'hA3,       0, 32'h0));
    tbl.push_back(mk(1, 6, 32'hBAD,      0, 4, 1,  4, 0, 1, 32'hA1,       0,  1, 32'hA4,       1, 32'hA1));
    tbl.push_back(mk(0, 0, 32'h0,        1, 0, 0,  4, 1, 1, 32'hA1,       0,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 0, 0,  3, 1, 2, 32'hA2,       1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 0, 0,  2, 1, 3, 32'hA3,       1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 4, 0,  1, 1, 4, 32'hA4,       1,  1, 32'hA4,       0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 6, 1,  0, 0, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0));
    // duplicate regnum and $0 filter
    tbl.push_back(mk(1, 7, 32'h1,        0, 7, 0,  0, 0, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 7, 32'h2,        0, 7, 0,  1, 0, 7, 32'h1,        1,  1, 32'h1,        0, 32'h0));
    tbl.push_back(mk(1, 0, 32'hFF,       0, 7, 0,  C ? 1 : 2, 0, 7, C ? 32'h2 : 32'h1, 1, 1, 32'h2, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 7, 0,  C ? 1 : 2, 0, 7, C ? 32'h2 : 32'h1, 1, 1, 32'h2, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 7, 0,  C ? 1 : 2, 1, 7, C ? 32'h2 : 32'h1, 1, 1, 32'h2, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 7, 0,  C ? 0 : 1, !C, C ? 5'd0 : 5'd7, C ? 32'h0 : 32'h2, 1,
                     !C, C ? 32'h0 : 32'h2, 0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 7, 0,  0, 0, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0));
    // full queue: pop only, then push and pop together
    tbl.push_back(mk(1, 1, 32'hB1,       0, 0, 0,  0, 0, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 2, 32'hB2,       0, 0, 0,  1, 0, 1, 32'hB1,       1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 3, 32'hB3,       0, 0, 0,  2, 0, 1, 32'hB1,       1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 4, 32'hB4,       0, 0, 0,  3, 0, 1, 32'hB1,       1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 8, 32'hC8,       1, 0, 0,  4, 1, 1, 32'hB1,       0,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(1, 8, 32'hC8,       1, 8, 0,  3, 1, 2, 32'hB2,       1,  0, 32'h0,        0, 32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 8, 2,  3, 0, 3, 32'hB3,       1,  1, 32'hC8,       0, 32'h0));

    // Reset state, checked while reset is still asserted and after release.
    #2;
    check("rst_empty", 0, 32'(empty), 32'h1);
    check("rst_count", 0, 32'(count), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("idle_ready", 0, 32'(in_ready), 32'h1);
    check("idle_we",    0, 32'(writeenable), 32'h0);
    check("idle_full",  0, 32'(full), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clock);
      drive(tbl[i].v, tbl[i].rn, tbl[i].d, tbl[i].de, tbl[i].l1, tbl[i].l2);
      #1;
      check("count",       i, 32'(count),       32'(tbl[i].cnt));
      check("full",        i, 32'(full),        32'(tbl[i].cnt == 4));
      check("empty",       i, 32'(empty),       32'(tbl[i].cnt == 0));
      check("writeenable", i, 32'(writeenable), 32'(tbl[i].we));
      check("wr_regnum",   i, 32'(wr_regnum),   32'(tbl[i].wrn));
      check("wr_data",     i, wr_data,          tbl[i].wd);
      check("in_ready",    i, 32'(in_ready),    32'(tbl[i].rdy));
      check("lk1_hit",     i, 32'(lk1_hit),     32'(tbl[i].h1));
      check("lk1_data",    i, lk1_data,         tbl[i].d1);
      check("lk2_hit",     i, 32'(lk2_hit),     32'(tbl[i].h2));
      check("lk2_data",    i, lk2_data,         tbl[i].d2);
    end

    // Asynchronous reset with three entries pending: clears without a clock edge.
    @(negedge clock);
    drive(0, 0, 32'h0, 0, 8, 3);
    #1;
    check("pre_rst_count", 0, 32'(count), 32'h3);
    reset = 1'b1;
    #1;
    check("arst_count", 0, 32'(count), 32'h0);
    check("arst_empty", 0, 32'(empty), 32'h1);
    check("arst_ready", 0, 32'(in_ready), 32'h1);
    check("arst_wrn",   0, 32'(wr_regnum), 32'h0);
    check("arst_wd",    0, wr_data, 32'h0);
    check("arst_hit1",  0, 32'(lk1_hit), 32'h0);
    check("arst_d1",    0, lk1_data, 32'h0);
    check("arst_hit2",  0, 32'(lk2_hit), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("post_rst_count", 0, 32'(count), 32'h0);

    // Same-register pushes: merged when coalescing, two writes otherwise.
    drive(1, 9, 32'h10, 0, 9, 0);
    @(negedge clock);
    drive(1, 9, 32'h20, 0, 9, 0);
    @(negedge clock);
    drive(0, 0, 32'h0, 0, 9, 0);
    #1;
    check("co_count", 0, 32'(count), C ? 32'h1 : 32'h2);
    check("co_lk",    0, lk1_data, 32'h20);
    drain_enable = 1'b1;
    #1;
    check("co_we0", 0, 32'(writeenable), 32'h1);
    check("co_wd0", 0, wr_data, C ? 32'h20 : 32'h10);
    @(negedge clock);
    #1;
    check("co_we1", 0, 32'(writeenable), C ? 32'h0 : 32'h1);
    check("co_wd1", 0, wr_data, C ? 32'h0 : 32'h20);
    @(negedge clock);
    #1;
    check("co_empty", 0, 32'(empty), 32'h1);
    drive(0, 0, 32'h0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
